// File: rtl/sram_rr_arbiter_2p_if.sv
// Request/response bundle between two clients and sram_rr_arbiter_2p.
//   master : client side (drives requests, receives ready and read responses)
//   slave  : arbiter side
// Signals:
//   req_valid[1:0]  request valid per requester
//   req_ready[1:0]  grant, combinational from req_valid
//   req_we[1:0]     1 = write, 0 = read
//   req_addr0/1     request address per requester
//   req_wdata0/1    write data per requester
//   rsp_valid[1:0]  one-cycle read response pulse per requester
//   rsp_rdata       shared read data, qualified by rsp_valid
interface sram_rr_arbiter_2p_if #(
   parameter int BITS       = 39,
   parameter int ADDR_WIDTH = 11
);
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0]            req_we;
   logic [ADDR_WIDTH-1:0] req_addr0;
   logic [ADDR_WIDTH-1:0] req_addr1;
   logic [BITS-1:0]       req_wdata0;
   logic [BITS-1:0]       req_wdata1;
   logic [1:0]            rsp_valid;
   logic [BITS-1:0]       rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_rr_arbiter_2p.sv
// Two-requester round-robin arbiter in front of one single-port fakeram7
// macro (1-cycle read). One access per cycle, strict acceptance order at the
// macro, every macro pin driven from a flop.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          sram_rr_arbiter_2p_if.slave: request channel + read response
//   ram_ce/we    macro ce_in / we_in
//   ram_addr     macro addr_in
//   ram_wd       macro wd_in (zero on reads)
//   ram_rd       macro rd_out
// Build option:
//   SRAM_ARB_RDATA_REG_EN  register rsp_valid/rsp_rdata (read latency 3 edges
//                          instead of 2; rsp_rdata holds between responses)
module sram_rr_arbiter_2p #(
   parameter int BITS       = 39,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sram_rr_arbiter_2p_if.slave   bus,
   output logic                  ram_ce,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [BITS-1:0]       ram_wd,
   input  logic [BITS-1:0]       ram_rd
);

   logic       last;     // requester that won the most recent accept
   logic [1:0] grant;    // one-hot or zero
   logic       accept;
   logic       sel;      // index of the granted requester
   logic [1:0] pend;     // read accepted at the last edge, macro not yet sampled
   logic [1:0] pend1;    // macro has sampled the read, ram_rd valid this cycle

   // Contention goes to the requester that did not win last time.
   always_comb begin
      grant = '0;
      case (bus.req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

   assign bus.req_ready = grant;
   assign accept        = |grant;
   assign sel           = grant[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last     <= 1'b1;
         ram_ce   <= 1'b0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_wd   <= '0;
         pend     <= '0;
         pend1    <= '0;
      end else begin
         pend  <= grant & ~bus.req_we;
         pend1 <= pend;
         if (accept) begin
            last     <= sel;
            ram_ce   <= 1'b1;
            ram_we   <= bus.req_we[sel];
            ram_addr <= sel ? bus.req_addr1 : bus.req_addr0;
            if (bus.req_we[sel])
               ram_wd <= sel ? bus.req_wdata1 : bus.req_wdata0;
            else
               ram_wd <= '0;
         end else begin
            // address and data hold so idle macro pins stay quiet
            ram_ce <= 1'b0;
            ram_we <= 1'b0;
         end
      end
   end

`ifdef SRAM_ARB_RDATA_REG_EN
   logic [1:0]      rsp_valid_q;
   logic [BITS-1:0] rsp_rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= pend1;
         if (|pend1)
            rsp_rdata_q <= ram_rd;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
`else
   assign bus.rsp_valid = pend1;
   assign bus.rsp_rdata = ram_rd;
`endif

endmodule
